reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Round-robin write arbiter that shares one 64-bit register (`Register_64bit`-style write port: `en_reg`/`d_in`) among four requesters. At most one write is accepted per cycle. A requester may hold ownership for a bounded burst of consecutive writes. Arbitration, grant, and write-port outputs are all registered, so the block drops directly into the register's write path.

## Interface
Parameters:
- `WIDTH`, 64: data width of each requester and of the write port.
- `MAX_HOLD`, 4: maximum consecutive writes per ownership; legal range 1..15.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  write request, one bit per requester.
- `hold`  in  4  keep ownership after the current write; meaningful only with the matching `req`.
- `wdata`  in  4*WIDTH  requester i data on `wdata[i*WIDTH +: WIDTH]`.
- `gnt`  out  4  one-hot; requester i's write was accepted at the previous edge.
- `en_reg`  out  1  write enable to the register.
- `d_in`  out  WIDTH  write data to the register.
- `busy`  out  1  high while in state GRANT.

## Operation
- Each edge, the block samples `req`/`hold`/`wdata`. A sampled `req[i]`=1 is a new write request.
- State `ptr` (2 bits) is the highest-priority requester. Priority order is ptr, ptr+1, ptr+2, ptr+3 mod 4.
- FSM states: IDLE, GRANT. State `owner` (2 bits), `hold_cnt` (4 bits).
- IDLE:
  - No `req`: stay IDLE; `gnt`=0, `en_reg`=0, `d_in` unchanged.
  - Any `req`: select the first requesting index k in priority order.
  - Go to GRANT with `owner`=k, `hold_cnt`=0.
  - Register `gnt`=1<<k, `en_reg`=1, `d_in`=wdata[k].
- GRANT, continue case: `req[owner]` & `hold[owner]` & (`hold_cnt` < MAX_HOLD-1).
  - Stay in GRANT; `hold_cnt`+=1.
  - `gnt`=1<<owner, `en_reg`=1, `d_in`=wdata[owner].
  - Other requests wait.
- GRANT, otherwise (release):
  - Set `ptr`=owner+1 mod 4.
  - Re-arbitrate in the same cycle using the new ptr. The old owner is lowest priority but still eligible.
  - Any `req`: new grant as in IDLE, with `hold_cnt`=0.
  - No `req`: go IDLE; `gnt`=0, `en_reg`=0.
- Requester rule: a requester seeing `gnt[i]` without `hold` must deassert `req[i]` in that same cycle. Otherwise the next edge counts it as a new request.
- `ptr` advances only on release, never in IDLE. Fairness: the old owner goes last.
- MAX_HOLD=1 means no bursts; `hold` is ignored.
- `en_reg`=1 iff exactly one `gnt` bit is 1. `gnt` is never multi-hot.

## Timing
- Reset values: `gnt`=0, `en_reg`=0, `d_in`=0, `busy`=0, state IDLE, `ptr`=0, `owner`=0, `hold_cnt`=0.
- Reset overrides everything, including mid-burst. The cycle after `rst` deasserts, outputs are the reset values.
- Latency: `req` sampled at edge E → `gnt`/`en_reg`/`d_in` valid in cycle E..E+1 → register captures at E+1.
- Data: the value written is the `wdata` sampled at E. Later changes to `wdata` do not affect `d_in` until the next grant.
- Throughput: one write per cycle. Back-to-back grants to different requesters have no bubble.
- Burst length: an owner holding continuously gets exactly MAX_HOLD consecutive writes, then is forced to release.
- `hold[owner]` dropped (or `req` dropped) mid-burst: release at that edge.
- Simultaneous release and new requests: the new grant is issued at the same edge with no idle cycle.
- `hold` on a non-owner, or `hold` without `req`: no effect.

## Test plan
- Reset then `req`=0010, `wdata[1]`=64'hA5: one cycle later `gnt`=0010, `en_reg`=1, `d_in`=64'hA5; next cycle `gnt`=0, `ptr`=2.
- `req`=1111 for one cycle only, each requester drops after its grant: grants 0001, 0010, 0100, 1000 on consecutive cycles; `en_reg` high 4 cycles; data matches each requester.
- MAX_HOLD=4, requester 2 holds `req`/`hold` continuously while `req[0]`=1: gnt 0100 ×4, then 0001; `busy` stays high throughout.
- Requester 3 holding with `hold` dropped after 2 writes, `req[1]` pending: gnt 1000, 1000, then 0010.
- `rst` asserted during the 2nd cycle of a burst: the next cycle shows `gnt`=0, `en_reg`=0, `d_in`=0, IDLE. A subsequent `req`=1111 grants requester 0 first.
- No requests for 10 cycles after traffic: `en_reg`=0, `gnt`=0, `busy`=0, `d_in` holds the last written value.

Source files
------------

// File: rtl/reg_write_arbiter_if.sv
// Write-request bundle between four requesters and the register arbiter.
// The requester side drives req/hold/wdata; the arbiter drives the rest.
interface reg_write_arbiter_if #(
    parameter int WIDTH = 64
);
    logic [3:0]         req;
    logic [3:0]         hold;
    logic [4*WIDTH-1:0] wdata;
    logic [3:0]         gnt;
    logic               en_reg;
    logic [WIDTH-1:0]   d_in;
    logic               busy;

    modport master (
        output req, hold, wdata,
        input  gnt, en_reg, d_in, busy
    );

    modport slave (
        input  req, hold, wdata,
        output gnt, en_reg, d_in, busy
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register write port among four requesters,
// with bounded ownership bursts and fully registered outputs.
module reg_write_arbiter #(
    parameter int WIDTH    = 64,
    parameter int MAX_HOLD = 4
) (
    input logic               clk,
    input logic               rst,
    reg_write_arbiter_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_e;

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       owner_q, owner_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             en_q, en_d;
    logic [WIDTH-1:0] d_q, d_d;

    logic       cont;
    logic       found;
    logic [1:0] arb_ptr;
    logic [1:0] pick;
    logic [1:0] idx;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        en_d    = 1'b0;
        d_d     = d_q;
        found   = 1'b0;
        pick    = '0;
        idx     = '0;

        cont = (state_q == GRANT)
             && bus.req[owner_q]
             && bus.hold[owner_q]
             && (cnt_q < 4'(MAX_HOLD - 1));

        // On release the old owner drops to lowest priority immediately.
        arb_ptr = (state_q == GRANT) ? owner_q + 2'd1 : ptr_q;

        for (int i = 0; i < 4; i++) begin
            idx = arb_ptr + 2'(i);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end

        if (cont) begin
            cnt_d = cnt_q + 4'd1;
            gnt_d = 4'b0001 << owner_q;
            en_d  = 1'b1;
            d_d   = bus.wdata[owner_q*WIDTH +: WIDTH];
        end else begin
            if (state_q == GRANT)
                ptr_d = arb_ptr;
            if (found) begin
                state_d = GRANT;
                owner_d = pick;
                cnt_d   = '0;
                gnt_d   = 4'b0001 << pick;
                en_d    = 1'b1;
                d_d     = bus.wdata[pick*WIDTH +: WIDTH];
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            en_q    <= 1'b0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            en_q    <= en_d;
            d_q     <= d_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.en_reg = en_q;
    assign bus.d_in   = d_q;
    assign bus.busy   = (state_q == GRANT);
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: default MAX_HOLD=4 instance plus a
// MAX_HOLD=1 instance for the no-burst case.
module tb_reg_write_arbiter;
    localparam int W = 64;

    localparam logic [W-1:0] W0 = 64'h1111_0000_0000_0000;
    localparam logic [W-1:0] W1 = 64'h2222_0000_0000_0001;
    localparam logic [W-1:0] W2 = 64'h3333_0000_0000_0002;
    localparam logic [W-1:0] W3 = 64'h4444_0000_0000_0003;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs   = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    reg_write_arbiter_if #(.WIDTH(W)) bus ();
    reg_write_arbiter_if #(.WIDTH(W)) b1 ();

    reg_write_arbiter #(.WIDTH(W), .MAX_HOLD(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    reg_write_arbiter #(.WIDTH(W), .MAX_HOLD(1)) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(b1)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic out(input string tag,
                       input logic [3:0] g,
                       input logic e,
                       input logic [W-1:0] d,
                       input logic b);
        chk({tag, ".gnt"},  64'(bus.gnt),    64'(g));
        chk({tag, ".en"},   64'(bus.en_reg), 64'(e));
        chk({tag, ".d"},    bus.d_in,        d);
        chk({tag, ".busy"}, 64'(bus.busy),   64'(b));
    endtask

    initial begin
        bus.req   = '0;
        bus.hold  = '0;
        bus.wdata = '0;
        b1.req    = '0;
        b1.hold   = '0;
        b1.wdata  = '0;

        step();
        step();
        rst = 1'b0;
        step();
        out("reset", 4'b0000, 1'b0, '0, 1'b0);

        bus.wdata = {W3, W2, 64'hA5, W0};
        bus.req = 4'b0010;
        step();
        out("t1a", 4'b0010, 1'b1, 64'hA5, 1'b1);
        bus.req = 4'b0000;
        step();
        out("t1b", 4'b0000, 1'b0, 64'hA5, 1'b0);

        // ptr must now be 2, so 3 beats 1.
        bus.req = 4'b1010;
        step();
        out("ptr2", 4'b1000, 1'b1, W3, 1'b1);
        bus.req = 4'b0000;
        step();

        bus.wdata = {W3, W2, W1, W0};
        bus.req = 4'b1111;
        step();
        out("rr0", 4'b0001, 1'b1, W0, 1'b1);
        bus.req = 4'b1110;
        step();
        out("rr1", 4'b0010, 1'b1, W1, 1'b1);
        bus.req = 4'b1100;
        step();
        out("rr2", 4'b0100, 1'b1, W2, 1'b1);
        bus.req = 4'b1000;
        step();
        out("rr3", 4'b1000, 1'b1, W3, 1'b1);
        bus.req = 4'b0000;
        step();
        out("rr4", 4'b0000, 1'b0, W3, 1'b0);

        bus.req  = 4'b0100;
        bus.hold = 4'b0100;
        step();
        out("burst1", 4'b0100, 1'b1, W2, 1'b1);
        bus.req = 4'b0101;
        step();
        out("burst2", 4'b0100, 1'b1, W2, 1'b1);
        step();
        out("burst3", 4'b0100, 1'b1, W2, 1'b1);
        step();
        out("burst4", 4'b0100, 1'b1, W2, 1'b1);
        step();
        out("burst_rel", 4'b0001, 1'b1, W0, 1'b1);
        bus.req  = 4'b0000;
        bus.hold = 4'b0000;
        step();
        out("burst_idle", 4'b0000, 1'b0, W0, 1'b0);

        bus.req  = 4'b1000;
        bus.hold = 4'b1000;
        step();
        out("drop1", 4'b1000, 1'b1, W3, 1'b1);
        bus.req = 4'b1010;
        step();
        out("drop2", 4'b1000, 1'b1, W3, 1'b1);
        bus.req  = 4'b0010;
        bus.hold = 4'b0000;
        step();
        out("drop3", 4'b0010, 1'b1, W1, 1'b1);
        bus.req = 4'b0000;
        step();

        bus.req  = 4'b0001;
        bus.hold = 4'b0001;
        step();
        out("rb1", 4'b0001, 1'b1, W0, 1'b1);
        step();
        out("rb2", 4'b0001, 1'b1, W0, 1'b1);
        rst = 1'b1;
        step();
        out("rst_mid", 4'b0000, 1'b0, '0, 1'b0);
        rst      = 1'b0;
        bus.req  = 4'b0000;
        bus.hold = 4'b0000;
        step();
        out("rst_after", 4'b0000, 1'b0, '0, 1'b0);
        bus.req = 4'b1111;
        step();
        out("rst_ptr0", 4'b0001, 1'b1, W0, 1'b1);
        bus.req = 4'b0000;
        step();

        for (int i = 0; i < 10; i++) begin
            step();
            out("idle", 4'b0000, 1'b0, W0, 1'b0);
        end

        b1.wdata = {W3, W2, W1, W0};
        b1.req   = 4'b0011;
        b1.hold  = 4'b0011;
        step();
        chk("mh1_a", 64'(b1.gnt), 64'(4'b0001));
        step();
        chk("mh1_b", 64'(b1.gnt), 64'(4'b0010));
        chk("mh1_bd", b1.d_in, W1);
        step();
        chk("mh1_c", 64'(b1.gnt), 64'(4'b0001));
        b1.req  = 4'b0000;
        b1.hold = 4'b0000;
        step();
        chk("mh1_d", 64'(b1.gnt), 64'(4'b0000));
        chk("mh1_busy", 64'(b1.busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
